router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
Parametrised, buffered successor to the combinational 1-to-4 address router. It steers each input word to one of NUM_PORTS outputs selected by addr, and buffers it in a per-port FIFO. Each output uses a valid/ready handshake, so a stalled consumer back-pressures only its own port. The block sits between a single producer and NUM_PORTS independent consumers.

Parameters:
DATA_WIDTH, 32, width of each data word
NUM_PORTS, 4, number of output ports; legal range 2..16
FIFO_DEPTH, 4, entries per output FIFO; power of 2, >= 2
ADDR_WIDTH, $clog2(NUM_PORTS), width of addr; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  DATA_WIDTH  input word
din_en  input  1  input valid
addr  input  ADDR_WIDTH  destination port index
din_ready  output  1  high when the FIFO addressed this cycle is not full
dout  output  NUM_PORTS*DATA_WIDTH  flattened outputs; port p at [p*DATA_WIDTH +: DATA_WIDTH]
dout_valid  output  NUM_PORTS  per-port head-of-FIFO valid
dout_ready  input  NUM_PORTS  per-port consumer ready
oor_err  output  1  sticky flag: an out-of-range address was accepted

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- While reset is high:
  - all FIFO pointers and counts clear; dout_valid = 0; oor_err = 0; dout = 0.
  - din_ready is held at 0 during reset.
  - Reset asserted mid-transfer discards all buffered words. No pop handshake completes in that cycle.
- Target port: tgt = addr if addr < NUM_PORTS, else NUM_PORTS-1 (out-of-range addresses default to the last port).
- din_ready:
  - Combinational: din_ready = !full[tgt] && !reset.
  - No dependence on din_en. No same-cycle bypass of a full FIFO, so a concurrent pop on a full port does not allow a push.
- Push: when din_en && din_ready at a clock edge, din is written to FIFO tgt.
  - din_en with din_ready low means the word is not accepted. The producer must hold din/addr/din_en stable until it is accepted.
- Pop: per port p, when dout_valid[p] && dout_ready[p] at a clock edge, the FIFO p head advances.
  - dout_ready[p] while dout_valid[p] = 0 has no effect.
- Latency: a word accepted at edge t appears on dout_valid/dout of its port after edge t (one cycle). There is no combinational path from din to dout.
- Output registers:
  - dout_valid[p] = (count[p] != 0). dout slice p = the FIFO p head entry.
  - Both are driven from registers or the storage read, not from inputs.
- Per-port FIFO:
  - Write and read pointers each log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH, width log2(FIFO_DEPTH)+1.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Simultaneous push and pop on the same non-full, non-empty port: count unchanged, both pointers advance.
  - Push to an empty port with dout_ready high: the word is not popped in the same cycle; it becomes visible the next cycle.
- Ports are independent: one port at full does not affect acceptance to any other port.
- Ordering: FIFO order is preserved per port. There are no ordering guarantees across ports.
- oor_err is set on an accepted push whose addr >= NUM_PORTS, and is cleared only by reset. It never asserts when NUM_PORTS is a power of 2.

Optional Feature:
Macro ROUTER_FIFO_ZERO_IDLE_EN.
- Defined: each dout slice is forced to all-zeros whenever its dout_valid is 0. This matches the legacy router's zero-when-idle outputs.
- Undefined: dout slices of empty ports are don't-care (stale head contents). This saves the per-port output AND gating.
- Handshake, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset, then din_en=0 for 5 cycles:
  - Required: dout_valid=4'b0000, din_ready=1, oor_err=0.
  - With ROUTER_FIFO_ZERO_IDLE_EN defined, dout is all zero.
- Single route: din=32'hA5A5_0001, addr=2, din_en for 1 cycle, all dout_ready=1.
  - Required: the next cycle, dout_valid=4'b0100 and dout[95:64]=32'hA5A5_0001.
  - The following cycle, dout_valid=0.
- Backpressure: dout_ready[1]=0; push 5 words 1..5 to addr=1.
  - Required: words 1..4 accepted; din_ready=0 while presenting word 5.
  - Pushes to addr=0 are still accepted.
  - Then raise dout_ready[1] and hold word 5: outputs are 1,2,3,4,5 in order, one per cycle, with word 5 accepted the cycle after the first pop.
- Simultaneous push/pop: keep port 3 at count=2 and push to it while dout_ready[3]=1 for 6 cycles.
  - Required: count stays 2 and there is no stall.
  - Order is preserved across pointer wrap-around.
- Out-of-range (NUM_PORTS=3, ADDR_WIDTH=2): push din=32'h0000_00FF with addr=3.
  - Required: the word appears on port 2; oor_err=1 and stays 1 until reset.
- Reset mid-operation: fill port 0 with 3 words, then assert reset for 1 cycle.
  - Required: dout_valid=0 afterwards and none of the 3 words appears after reset.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo: steers each input word to one of NUM_PORTS outputs by addr and
// buffers it in a per-port FIFO. Each output has a valid/ready handshake, so a
// stalled consumer only back-pressures its own port. Out-of-range addresses go
// to the last port and raise the sticky oor_err flag.
//
// Optional build macro: ROUTER_FIFO_ZERO_IDLE_EN
//   defined   - each dout slice reads all-zeros while its dout_valid is low
//   undefined - dout slices of empty ports show stale head contents
module router_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            din_en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  output logic                            din_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]            dout_valid,
  input  logic [NUM_PORTS-1:0]            dout_ready,
  output logic                            oor_err
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ADDR_SPAN = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] tgt;
  logic                  addr_oor;
  logic                  push;
  logic [NUM_PORTS-1:0]  full;
  logic [ADDR_SPAN-1:0]  full_ext;
  logic                  oor_err_q;
  logic                  oor_err_d;

  // Resolve the destination port, the producer-side ready and the sticky error
  always_comb begin
    addr_oor = (32'(addr) >= 32'(NUM_PORTS));
    tgt      = addr_oor ? ADDR_WIDTH'(NUM_PORTS - 1) : addr;
    // Pad the full vector so any encodable addr value indexes a real bit
    full_ext = '0;
    full_ext[NUM_PORTS-1:0] = full;
    // A full FIFO is never bypassed, even if it pops this same cycle
    din_ready = !full_ext[tgt] && !reset;
    push      = din_en && din_ready;
    oor_err_d = oor_err_q | (push & addr_oor);
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_err_q <= 1'b0;
    end else begin
      oor_err_q <= oor_err_d;
    end
  end

  assign oor_err = oor_err_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_p;
    logic                  pop_p;
    logic                  valid_p;
    logic [DATA_WIDTH-1:0] head;

    // Per-port push/pop decode and next-state pointers and occupancy
    always_comb begin
      valid_p  = (count_q != '0) && !reset;
      push_p   = push && (tgt == ADDR_WIDTH'(gi));
      pop_p    = valid_p && dout_ready[gi];
      wr_ptr_d = push_p ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_p  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_p, pop_p})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      head = mem[rd_ptr_q];
    end

    // Pointer and count registers; reset discards everything buffered
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
      if (push_p) begin
        mem[wr_ptr_q] <= din;
      end
    end

    assign full[gi]       = (count_q == CNT_W'(FIFO_DEPTH));
    assign dout_valid[gi] = valid_p;

`ifdef ROUTER_FIFO_ZERO_IDLE_EN
    assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = valid_p ? head : '0;
`else
    assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = reset ? '0 : head;
`endif
  end

endmodule

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: a driver issues directed and random pushes and keeps
// a per-port queue of words the DUT must hold; an independent monitor compares
// the DUT outputs against those queues every cycle and retires popped words.
// A second 3-port instance exercises out-of-range address handling.
`timescale 1ns/1ps
module tb_router_fifo;

  localparam int DW    = 32;
  localparam int NP    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW-1:0]     din = '0;
  logic              din_en = 1'b0;
  logic [1:0]        addr = '0;
  logic              din_ready;
  logic [NP*DW-1:0]  dout;
  logic [NP-1:0]     dout_valid;
  logic [NP-1:0]     dout_ready = '0;
  logic              oor_err;

  logic              din_ready3;
  logic [3*DW-1:0]   dout3;
  logic [2:0]        dout_valid3;
  logic [2:0]        dout_ready3 = 3'b111;
  logic              oor_err3;

  always #5 clk = ~clk;

  router_fifo #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_en(din_en), .addr(addr),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .oor_err(oor_err)
  );

  router_fifo #(.DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .reset(reset), .din(din), .din_en(din_en), .addr(addr),
    .din_ready(din_ready3), .dout(dout3), .dout_valid(dout_valid3),
    .dout_ready(dout_ready3), .oor_err(oor_err3)
  );

  int checks = 0;
  int fails  = 0;
  // Words currently held by each DUT port, oldest first
  logic [DW-1:0] exp_q [NP][$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Destination rule: in-range addresses map directly, others to the last port
  function automatic int route(input int a, input int np);
    return (a < np) ? a : np - 1;
  endfunction

  // Called at posedge+1; presents inputs, predicts acceptance, returns at next posedge+1
  task automatic step(input logic [DW-1:0] d, input int a, input logic en,
                      input logic [NP-1:0] rdy, output bit acc);
    int t;
    bit exp_rdy;
    din = d;
    addr = 2'(a);
    din_en = en;
    dout_ready = rdy;
    #1;
    t = route(a, NP);
    exp_rdy = (exp_q[t].size() < DEPTH);
    chk("din_ready", din_ready, exp_rdy);
    acc = en && exp_rdy;
    @(posedge clk);
    if (acc) begin
      exp_q[t].push_back(d);
      $display("push port=%0d data=%08h", t, d);
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    din_en = 1'b0;
    #1;
    chk("din_ready_in_reset", din_ready, 0);
    repeat (cycles) @(posedge clk);
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    #1;
    reset = 1'b0;
    $display("reset released");
  endtask

  // Monitor: checks valid/data/idle outputs at each negedge and retires pops
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("valid_in_reset", dout_valid, 0);
      end else begin
        chk("oor_err_pow2", oor_err, 0);
        for (int p = 0; p < NP; p++) begin
          chk($sformatf("valid[%0d]", p), dout_valid[p], (exp_q[p].size() != 0));
          if (dout_valid[p] && exp_q[p].size() != 0) begin
            chk($sformatf("data[%0d]", p), dout[p*DW +: DW], exp_q[p][0]);
            if (dout_ready[p]) begin
              $display("pop  port=%0d data=%08h", p, dout[p*DW +: DW]);
              void'(exp_q[p].pop_front());
            end
          end
`ifdef ROUTER_FIFO_ZERO_IDLE_EN
          else if (!dout_valid[p]) begin
            chk($sformatf("idle_zero[%0d]", p), dout[p*DW +: DW], 0);
          end
`endif
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit acc;
    int tries;
    bit held;
    logic [DW-1:0] rd;
    int ra;
    logic re;

    @(posedge clk);
    #1;
    do_reset(2);

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step('0, 0, 1'b0, '1, acc);
      chk("idle_valid", dout_valid, 0);
      chk("idle_oor", oor_err, 0);
    end

    // Single route to port 2, visible one cycle later then gone
    step(32'hA5A5_0001, 2, 1'b1, 4'hF, acc);
    chk("single_valid", dout_valid, 4'b0100);
    chk("single_data", dout[95:64], 32'hA5A5_0001);
    step('0, 0, 1'b0, 4'hF, acc);
    chk("single_gone", dout_valid, 0);

    // Backpressure on port 1
    for (int w = 1; w <= 4; w++) step(DW'(w), 1, 1'b1, 4'b1101, acc);
    step(32'd5, 1, 1'b1, 4'b1101, acc);
    chk("bp_full_ready", din_ready, 0);
    step(32'h100, 0, 1'b1, 4'b1101, acc);
    step(32'h101, 0, 1'b1, 4'b1101, acc);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 10) begin
      step(32'd5, 1, 1'b1, 4'hF, acc);
      tries++;
    end
    chk("bp_word5_tries", tries, 2);
    repeat (6) step('0, 0, 1'b0, 4'hF, acc);
    chk("bp_drained", dout_valid, 0);

    // Port 3 held at two entries with simultaneous push and pop
    step(32'h300, 3, 1'b1, 4'b0111, acc);
    step(32'h301, 3, 1'b1, 4'b0111, acc);
    for (int i = 0; i < 6; i++) begin
      step(32'h310 + DW'(i), 3, 1'b1, 4'hF, acc);
      chk("pp_no_stall", din_ready, 1);
      chk("pp_valid", dout_valid[3], 1);
    end
    repeat (4) step('0, 0, 1'b0, 4'hF, acc);

    // Random traffic; a refused word is held until accepted
    held = 1'b0;
    rd = '0;
    ra = 0;
    re = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        rd = $urandom;
        ra = $urandom_range(0, NP - 1);
        re = ($urandom_range(0, 3) != 0);
      end
      step(rd, ra, re, NP'($urandom), acc);
      held = re && !acc;
    end
    repeat (2 * DEPTH + 2) step('0, 0, 1'b0, '1, acc);
    chk("rand_drained", dout_valid, 0);

    // Reset in the middle of buffered data on port 0
    for (int i = 0; i < 3; i++) step(32'h700 + DW'(i), 0, 1'b1, '0, acc);
    chk("mid_filled", dout_valid, 4'b0001);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step('0, 0, 1'b0, '1, acc);
      chk("mid_after_reset", dout_valid, 0);
    end

    // Out-of-range address on the 3-port instance
    chk("oor3_init", oor_err3, 0);
    step(32'h0000_00FF, 3, 1'b1, '1, acc);
    chk("oor3_valid", dout_valid3, 3'b100);
    chk("oor3_data", dout3[95:64], 32'h0000_00FF);
    chk("oor3_flag", oor_err3, 1);
    for (int i = 0; i < 3; i++) begin
      step('0, 0, 1'b0, '1, acc);
      chk("oor3_sticky", oor_err3, 1);
    end
    step(32'h0000_0011, 1, 1'b1, '1, acc);
    chk("oor3_inrange_keeps", oor_err3, 1);
    do_reset(1);
    chk("oor3_cleared", oor_err3, 0);
    step('0, 0, 1'b0, '1, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
